// File: rtl/csa_multiword_sequencer.sv
// Sequences one 16-bit carry-select adder over WORDS slices to form a 16*WORDS-bit sum.
// Optional macro CSA_SEQ_SUB_EN adds a 'sub' port for A-B.
module carry_select_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        cout,
  output logic [15:0] sum
);
  logic [4:0] c;
  assign c[0] = cin;

  // Four 4-bit blocks; each precomputes both carry-in cases and selects on the incoming carry
  for (genvar g = 0; g < 4; g++) begin : g_blk
    logic [4:0] r0, r1;
    assign r0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
    assign r1 = r0 + 5'd1;
    assign sum[4*g +: 4] = c[g] ? r1[3:0] : r0[3:0];
    assign c[g+1]        = c[g] ? r1[4]   : r0[4];
  end

  assign cout = c[4];
endmodule

module csa_multiword_sequencer #(
  parameter  int WORDS = 4,
  localparam int W     = 16*WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef CSA_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WORDS-1:0][15:0] a_q, b_q, sum_q;
  logic [IW-1:0]          idx;
  logic                   carry_q, cout_q, sub_q, sub_in, last;
  logic [15:0]            sa, sb, sb_eff, ss;
  logic                   sc;

`ifdef CSA_SEQ_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  assign last = (idx == IW'(WORDS-1));

  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < WORDS; i++)
      if (idx == IW'(i)) begin
        sa = a_q[i];
        sb = b_q[i];
      end
  end

  // Subtraction is A + ~B + 1: the +1 enters through the initial carry
  assign sb_eff = sub_q ? ~sb : sb;

  carry_select_adder_16bit u_csa (
    .a(sa), .b(sb_eff), .cin(carry_q), .cout(sc), .sum(ss)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          sub_q   <= sub_in;
          carry_q <= sub_in ? 1'b1 : cin;
          sum_q   <= '0;
          idx     <= '0;
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++)
            if (idx == IW'(i)) sum_q[i] <= ss;
          carry_q <= sc;
          if (last) begin
            cout_q <= sc;
            idx    <= '0;
          end else begin
            idx    <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_csa_multiword_sequencer.sv
// Directed bench for csa_multiword_sequencer with an arithmetic reference model and per-cycle compare.
module tb_csa_multiword_sequencer;
  localparam int WORDS = 4;
  localparam int W     = 16*WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0, sub_i = 1'b0;
  logic         in_ready, out_valid, cout;
  logic [W-1:0] sum;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  csa_multiword_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef CSA_SEQ_SUB_EN
    .sub(sub_i),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  // Reference model: phase 0 idle, 1 busy, 2 result presented
  int           m_phase = 0, m_cnt = 0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [W:0] r;
    logic       s;
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_sum = '0; m_cout = 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
`ifdef CSA_SEQ_SUB_EN
          s = sub_i;
`else
          s = 1'b0;
`endif
          if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
          else   r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
          m_sum = r[W-1:0]; m_cout = r[W];
          m_phase = 1; m_cnt = 0;
        end
        1: begin
          m_cnt++;
          if (m_cnt == WORDS) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out_valid", (W+1)'(out_valid), (W+1)'(m_phase == 2));
    if (!rst) chk("in_ready", (W+1)'(in_ready), (W+1)'(m_phase == 0));
    if (m_phase != 1) begin
      chk("sum", {1'b0, sum}, {1'b0, m_sum});
      chk("cout", (W+1)'(cout), (W+1)'(m_cout));
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic ts, input logic [W-1:0] xs, input logic xc,
                       input int hold, input string nm);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub_i = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_; cin = ~tc; sub_i = ~ts;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, (W+1)'(lat), (W+1)'(WORDS));
    chk({nm, "_sum"}, {1'b0, sum}, {1'b0, xs});
    chk({nm, "_cout"}, (W+1)'(cout), (W+1)'(xc));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = ta ^ W'(k + 1); b = tb_ + W'(k + 3); cin = ~tc;
      @(posedge clk); #1;
      chk({nm, "_hold_in_ready"}, (W+1)'(in_ready), '0);
      chk({nm, "_hold_sum"}, {1'b0, sum}, {1'b0, xs});
      chk({nm, "_hold_cout"}, (W+1)'(cout), (W+1)'(xc));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_release_valid"}, (W+1)'(out_valid), '0);
    chk({nm, "_release_ready"}, (W+1)'(in_ready), (W+1)'(1));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_sum", {1'b0, sum}, '0);
    chk("reset_valid", (W+1)'(out_valid), '0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post_reset_ready", (W+1)'(in_ready), (W+1)'(1));

    do_op(64'd4, 64'd3, 1'b0, 1'b0, 64'd7, 1'b0, 0, "add_4_3");
    do_op(64'd5, 64'd6, 1'b1, 1'b0, 64'd12, 1'b0, 0, "add_5_6_c");
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 0, "ripple_all");
    do_op(64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 0, "cross_slice");
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
          64'h2222_2222_2222_2211, 1'b0, 5, "backpressure");
`ifdef CSA_SEQ_SUB_EN
    do_op(64'd5, 64'd6, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, "sub_5_6");
    do_op(64'd9, 64'd7, 1'b0, 1'b1, 64'd2, 1'b1, 0, "sub_9_7");
    do_op(64'd9, 64'd7, 1'b1, 1'b0, 64'd17, 1'b0, 0, "sub0_add");
`endif

    // Abort mid-operation: no result may appear afterwards
    @(negedge clk);
    a = 64'h0000_0000_0000_FFFF; b = 64'd1; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("abort_valid", (W+1)'(out_valid), '0);
    chk("abort_sum", {1'b0, sum}, '0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < WORDS + 3; k++) begin
      @(posedge clk); #1;
      chk("abort_no_result", (W+1)'(out_valid), '0);
    end
    chk("abort_idle_ready", (W+1)'(in_ready), (W+1)'(1));

    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'd1, 1'b1, 0, "top_wrap");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/csa_multiword_sequencer.md
Name: csa_multiword_sequencer

Overview:
Sequences one shared 16-bit carry select adder (`carry_select_adder_16bit`, ports a, b, cin, cout, sum) to perform WORDS*16-bit additions. It feeds one 16-bit slice per cycle and chains the carry through a register. Operands are accepted and results returned through valid/ready handshakes. It sits between wide-operand producers and consumers that cannot afford a full-width adder.

Parameters:
WORDS, 4, number of 16-bit slices per operation; legal range 1..16; operand width W = 16*WORDS.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operand set valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  W  operand A.
b  input  W  operand B.
cin  input  1  carry into slice 0.
out_valid  output  1  sum/cout valid.
out_ready  input  1  consumer accepts result.
sum  output  W  result A+B+cin, modulo 2^W.
cout  output  1  carry out of the top slice.

Behaviour:
- Reset (async assert, any state): state=IDLE, slice index=0, carry reg=0, sum=0, cout=0, out_valid=0. in_ready=1 once reset is released.
- State IDLE: in_ready=1.
  - On an edge with in_valid=1, capture a, b and cin into internal registers.
  - Clear the sum register, set index=0, set carry reg=cin, go to RUN.
- State RUN: in_ready=0, out_valid=0.
  - The adder is driven combinationally with a=A[16i+15:16i], b=B[16i+15:16i], cin=carry reg, where i=index.
  - Each edge: sum[16i+15:16i] <= adder sum; carry reg <= adder cout; index <= index+1.
  - On the edge where index==WORDS-1: cout <= adder cout, go to DONE, out_valid <= 1, index <= 0.
- State DONE: out_valid=1.
  - sum and cout are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid <= 0, go to IDLE.
  - in_valid is ignored in DONE; there is no same-cycle accept.
- Latency: out_valid rises exactly WORDS edges after the accepting edge. Minimum occupancy per operation is WORDS+2 cycles.
- Index counter width is clog2(WORDS), minimum 1 bit.
- WORDS=1: RUN lasts exactly one edge.
- Inputs a, b and cin may change freely after the accepting edge; only the captured copies are used.
- Overflow wraps modulo 2^W; the wrap is reported only through cout.
- Reset asserted mid-RUN or in DONE aborts the operation. No partial result is ever presented with out_valid=1.
- Only one adder instance exists. No combinational path from in_valid or out_ready to any output except via state.

Optional Feature:
CSA_SEQ_SUB_EN
- Defined: adds input port sub (1 bit), captured with the operands on the accepting edge.
  - sub=1: every B slice is bitwise inverted before the adder, and the carry reg is initialised to 1 (cin is ignored). Result is A-B mod 2^W; cout=1 means no borrow.
  - sub=0: plain addition, identical to the undefined case.
- Undefined: no sub port; addition only.

Test Plan:
- Reset then release -> sum=0, cout=0, out_valid=0, in_ready=1. Assert rst mid-RUN -> state IDLE, out_valid=0, no result emitted.
- WORDS=4: a=4, b=3, cin=0 accepted at edge k -> out_valid high after edge k+4, sum=7, cout=0. Also: a=5, b=6, cin=1 -> sum=12.
- a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0, cout=1 (carry ripples through all 4 slices).
- a=0x0000_0000_0000_FFFF, b=0, cin=1 -> sum=0x0000_0000_0001_0000, cout=0 (cross-slice carry via the carry reg).
- Backpressure: out_ready held 0 for 5 cycles in DONE while in_valid=1 with new operands -> sum/cout unchanged, in_ready=0, new operands not captured. out_ready=1 -> IDLE next edge.
- With CSA_SEQ_SUB_EN: a=5, b=6, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0. a=9, b=7, sub=1 -> sum=2, cout=1.
